// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Constants and types shared by the pipeline front end (fetch, decode,
//   hazard unit). Widths are word-addressed: one address = one 16-bit
//   instruction.
//
//   ADDR_W     PC / instruction memory address width
//   INSTR_W    instruction width
//   RESET_PC   PC loaded on reset
//   HLT_OP     opcode (instr[15:12]) that stops fetch
//   NOP_INSTR  value presented on the IF/ID instruction when it is not valid
//   fetch_state_e  fetch FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 16'h0000;
  localparam logic [3:0]         HLT_OP    = 4'hF;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Opcode lives in the top nibble of every instruction.
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage : cpu_pkg

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Instruction-memory read bus between the fetch stage and the IM.
//
//   im_addr   fetch -> IM   read address (word addressed)
//   im_rd_en  fetch -> IM   read enable
//   im_instr  IM -> fetch   instruction stored at im_addr
//
//   Protocol: fetch drives im_addr / im_rd_en from its PC register right
//   after each rising edge. While im_rd_en is high the IM samples im_addr
//   during clk low and returns im_instr, stable before the next rising
//   edge. There is no back-pressure: the IM always answers in that window.
//   With im_rd_en low the IM keeps its previous output.
//
//   Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
);

  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_instr;

  modport master (
    output im_addr,
    output im_rd_en,
    input  im_instr
  );

  modport slave (
    input  im_addr,
    input  im_rd_en,
    output im_instr
  );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
//   Generic pipeline register carrying an instruction, its PC+1 and a valid
//   bit. Used as the IF/ID register and reusable for later stages.
//
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         capture instr_i / pc_plus1_i and mark valid
//   bubble_i       insert a bubble (valid=0, instruction=NOP); wins over load
//   instr_i        incoming instruction
//   pc_plus1_i     incoming PC+1
//   instr_o        registered instruction (NOP whenever valid_o=0)
//   pc_plus1_o     registered PC+1
//   valid_o        register holds a real instruction
//
//   With neither load nor bubble the register holds (stall).
// ---------------------------------------------------------------------------
module ifid_reg #(
  parameter int unsigned           INSTR_W   = cpu_pkg::INSTR_W,
  parameter int unsigned           ADDR_W    = cpu_pkg::ADDR_W,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus1_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [ADDR_W-1:0]  pc_plus1_q, pc_plus1_d;
  logic               valid_q,    valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      // pc_plus1 is left as-is: it is meaningless while valid=0.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule : ifid_reg

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage: owns the PC, reads the instruction memory and fills the
//   IF/ID register. Handles hazard stalls, branch/jump redirects and HLT.
//
//   clk            system clock (IM reads while clk is low)
//   rst_n          asynchronous active-low reset
//   stall          hazard unit: hold PC, IF/ID and the fetch counter
//   redirect       taken branch/jump from a later stage; beats stall
//   redirect_pc    target of the redirect
//   im             IM read bus (master side): im_addr = PC register,
//                  im_rd_en = 1 while fetching, im_instr returned data
//   ifid_instr     IF/ID instruction (NOP_INSTR when not valid)
//   ifid_pc_plus1  IF/ID PC+1 of that instruction
//   ifid_valid     IF/ID holds a real instruction
//   halted         fetch stopped on an HLT
//   fetch_cnt      instructions delivered to IF/ID, saturating at all-ones
//   dbg_state      current FSM state
//
//   Latency: the PC presented after edge N has its instruction in IF/ID
//   after edge N+1.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned                      ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned                      INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [cpu_pkg::ADDR_W-1:0]       RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [3:0]                       HLT_OP    = cpu_pkg::HLT_OP,
  parameter logic [cpu_pkg::INSTR_W-1:0]      NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  instr_fetch_if.master         im,
  output logic [INSTR_W-1:0]    ifid_instr,
  output logic [ADDR_W-1:0]     ifid_pc_plus1,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic [15:0]           fetch_cnt,
  output cpu_pkg::fetch_state_e dbg_state
);

  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [15:0]        cnt_q,   cnt_d;

  logic [ADDR_W-1:0]  pc_plus1;
  logic               is_hlt;
  logic               ifid_load;
  logic               ifid_bubble;
  logic               rd_en;

  // Natural modulo-2^ADDR_W wrap: 16'hFFFF + 1 -> 16'h0000.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign is_hlt   = (opcode_of(im.im_instr) == HLT_OP);

  // Next-state / control. Priority in FETCH: redirect > stall > normal.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    rd_en       = 1'b0;

    unique case (state_q)
      FETCH: begin
        rd_en = 1'b1;
        if (redirect) begin
          // Squash whatever the IM returned this cycle (even an HLT).
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          ifid_load = 1'b1;
          cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (is_hlt) begin
            // HLT still goes to decode; PC stays on it.
            state_d = HALTED;
          end else begin
            pc_d = pc_plus1;
          end
        end
      end

      HALTED: begin
        // Stall is irrelevant here: nothing is being fetched.
        ifid_bubble = 1'b1;
        if (redirect) begin
          // An older branch resolved after the HLT was fetched.
          pc_d    = redirect_pc;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  ifid_reg #(
    .INSTR_W   (INSTR_W),
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (im.im_instr),
    .pc_plus1_i (pc_plus1),
    .instr_o    (ifid_instr),
    .pc_plus1_o (ifid_pc_plus1),
    .valid_o    (ifid_valid)
  );

  assign im.im_addr  = pc_q;
  assign im.im_rd_en = rd_en;
  assign halted      = (state_q == HALTED);
  assign fetch_cnt   = cnt_q;
  assign dbg_state   = state_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A behavioural IM samples im_addr on the
//   falling edge while im_rd_en is high. Default IM contents are
//   16'h1000 | addr[11:0], so no location decodes as HLT unless planted.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_cnt;
  fetch_state_e dbg_state;

  instr_fetch_if im_bus ();

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .im            (im_bus.master),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- instruction memory model ----------------
  logic [15:0] mem [65536];

  always @(negedge clk) begin
    if (im_bus.im_rd_en) im_bus.im_instr <= mem[im_bus.im_addr];
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] e_instr,
                          input logic [15:0] e_pc1, input logic e_valid);
    chk({tag, ".instr"}, 32'(ifid_instr), 32'(e_instr));
    chk({tag, ".pc1"},   32'(ifid_pc_plus1), 32'(e_pc1));
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(e_valid));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".valid"},  32'(ifid_valid), 32'd0);
    chk({tag, ".instr"},  32'(ifid_instr), 32'(16'h0000));
    chk({tag, ".pc1"},    32'(ifid_pc_plus1), 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
    chk({tag, ".cnt"},    32'(fetch_cnt), 32'd0);
    chk({tag, ".addr"},   32'(im_bus.im_addr), 32'(16'h0000));
    chk({tag, ".rd_en"},  32'(im_bus.im_rd_en), 32'd1);
    chk({tag, ".state"},  32'(dbg_state), 32'(FETCH));
  endtask

  logic [15:0] exp_cnt;
  logic [15:0] exp_pc;

  // ---------------- directed sequence ----------------
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h1000 | (16'(a) & 16'h0FFF);

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    repeat (2) step();
    chk_reset_values("rst");

    // Release reset while clk is low; first edge delivers instr@0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ifid($sformatf("seq%0d", i), 16'h1000 + 16'(i), 16'(i + 1), 1'b1);
    end
    chk("seq.cnt", 32'(fetch_cnt), 32'd4);
    chk("seq.addr", 32'(im_bus.im_addr), 32'd4);

    // One more fetch brings pc to 5, then stall for 3 cycles.
    step();
    chk_ifid("pre_stall", 16'h1004, 16'd5, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.addr", i), 32'(im_bus.im_addr), 32'd5);
      chk($sformatf("stall%0d.rd_en", i), 32'(im_bus.im_rd_en), 32'd1);
      chk_ifid($sformatf("stall%0d", i), 16'h1004, 16'd5, 1'b1);
      chk($sformatf("stall%0d.cnt", i), 32'(fetch_cnt), 32'd5);
    end
    stall = 1'b0;
    step();
    chk_ifid("unstall", 16'h1005, 16'd6, 1'b1);
    chk("unstall.cnt", 32'(fetch_cnt), 32'd6);

    // Redirect together with stall: redirect wins.
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    step();
    chk_ifid("redir", 16'h0000, 16'd6, 1'b0);
    chk("redir.addr", 32'(im_bus.im_addr), 32'h0040);
    chk("redir.cnt", 32'(fetch_cnt), 32'd6);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk_ifid("redir_tgt", 16'h1040, 16'h0041, 1'b1);
    chk("redir_tgt.cnt", 32'(fetch_cnt), 32'd7);

    // HLT at address 7, reached via a redirect to 6.
    mem[7] = 16'hF000;
    redirect = 1'b1; redirect_pc = 16'h0006;
    step();
    chk("to6.valid", 32'(ifid_valid), 32'd0);
    chk("to6.addr", 32'(im_bus.im_addr), 32'd6);
    redirect = 1'b0;
    step();
    chk_ifid("at6", 16'h1006, 16'd7, 1'b1);
    step();
    chk_ifid("hlt", 16'hF000, 16'd8, 1'b1);
    chk("hlt.halted", 32'(halted), 32'd1);
    chk("hlt.rd_en", 32'(im_bus.im_rd_en), 32'd0);
    chk("hlt.addr", 32'(im_bus.im_addr), 32'd7);
    chk("hlt.cnt", 32'(fetch_cnt), 32'd9);
    chk("hlt.state", 32'(dbg_state), 32'(HALTED));
    stall = 1'b1;  // ignored while halted
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("halt%0d.valid", i), 32'(ifid_valid), 32'd0);
      chk($sformatf("halt%0d.instr", i), 32'(ifid_instr), 32'h0000);
      chk($sformatf("halt%0d.halted", i), 32'(halted), 32'd1);
      chk($sformatf("halt%0d.addr", i), 32'(im_bus.im_addr), 32'd7);
      chk($sformatf("halt%0d.rd_en", i), 32'(im_bus.im_rd_en), 32'd0);
      chk($sformatf("halt%0d.cnt", i), 32'(fetch_cnt), 32'd9);
    end
    stall = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    chk("unhalt.halted", 32'(halted), 32'd0);
    chk("unhalt.valid", 32'(ifid_valid), 32'd0);
    chk("unhalt.addr", 32'(im_bus.im_addr), 32'h0010);
    chk("unhalt.rd_en", 32'(im_bus.im_rd_en), 32'd1);
    redirect = 1'b0;
    step();
    chk_ifid("resume", 16'h1010, 16'h0011, 1'b1);
    chk("resume.cnt", 32'(fetch_cnt), 32'd10);

    // Redirect in the same cycle as an HLT fetch: no halt.
    redirect = 1'b1; redirect_pc = 16'h0007;
    step();
    chk("to7.addr", 32'(im_bus.im_addr), 32'd7);
    redirect_pc = 16'h0020;  // IM returns the HLT during this cycle
    step();
    chk("hlt_sq.halted", 32'(halted), 32'd0);
    chk("hlt_sq.valid", 32'(ifid_valid), 32'd0);
    chk("hlt_sq.addr", 32'(im_bus.im_addr), 32'h0020);
    chk("hlt_sq.cnt", 32'(fetch_cnt), 32'd10);
    redirect = 1'b0;
    step();
    chk_ifid("after_sq", 16'h1020, 16'h0021, 1'b1);
    chk("after_sq.cnt", 32'(fetch_cnt), 32'd11);
    mem[7] = 16'h1007;

    // PC wrap at 16'hFFFF.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    chk("toFFFF.addr", 32'(im_bus.im_addr), 32'hFFFF);
    redirect = 1'b0;
    step();
    chk_ifid("wrap", 16'h1FFF, 16'h0000, 1'b1);
    chk("wrap.addr", 32'(im_bus.im_addr), 32'h0000);
    chk("wrap.cnt", 32'(fetch_cnt), 32'd12);
    step();
    chk_ifid("wrap1", 16'h1000, 16'h0001, 1'b1);
    chk("wrap1.cnt", 32'(fetch_cnt), 32'd13);

    // Run the counter up to saturation with uninterrupted fetches.
    exp_cnt = 16'd13;
    exp_pc  = 16'h0001;
    while (exp_cnt != 16'hFFFF) begin
      step();
      exp_cnt = exp_cnt + 16'd1;
      exp_pc  = exp_pc + 16'd1;
    end
    chk("satA.cnt", 32'(fetch_cnt), 32'hFFFF);
    chk("satA.addr", 32'(im_bus.im_addr), 32'(exp_pc));
    chk_ifid("satA", mem[exp_pc - 16'd1], exp_pc, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      exp_pc = exp_pc + 16'd1;
      chk($sformatf("sat%0d.cnt", i), 32'(fetch_cnt), 32'hFFFF);
      chk_ifid($sformatf("sat%0d", i), mem[exp_pc - 16'd1], exp_pc, 1'b1);
    end

    // Asynchronous reset pulsed while clk is low with ifid_valid=1.
    chk("pre_rst.valid", 32'(ifid_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_ifid("restart0", 16'h1000, 16'd1, 1'b1);
    chk("restart0.cnt", 32'(fetch_cnt), 32'd1);
    step();
    chk_ifid("restart1", 16'h1001, 16'd2, 1'b1);
    chk("restart1.cnt", 32'(fetch_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction memory (IM) and feeds the decode stage.
- Owns the program counter and drives the IM address and read enable.
- Captures the returned 16-bit instruction into the IF/ID pipeline register with a valid bit.
- Handles hazard stalls, branch/jump redirects and HLT detection.

Parameters:
- ADDR_W, 16, PC and IM address width (word addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value on reset
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch
- NOP_INSTR, 16'h0000, value driven on ifid_instr when ifid_valid=0

Ports:
- clk  in  1  system clock; IM reads while clk low
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  branch/jump taken, resolved in a later stage
- redirect_pc  in  16  target PC for redirect
- im_instr  in  16  instruction returned by IM for im_addr
- im_addr  out  16  IM read address (= pc register, combinational)
- im_rd_en  out  1  IM read enable
- ifid_instr  out  16  registered instruction to decode
- ifid_pc_plus1  out  16  registered PC+1 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HLT
- fetch_cnt  out  16  count of instructions delivered, saturating

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH
  - ifid_instr=NOP_INSTR, ifid_pc_plus1=0, ifid_valid=0
  - halted=0, fetch_cnt=0
  - Reset asserted mid-operation discards all in-flight state immediately.
- Timing:
  - im_addr=pc is valid after each posedge.
  - IM latches during clk low, so im_instr is stable before the next posedge.
  - Latency is one cycle: the PC presented in cycle N has its instruction in IF/ID after posedge N+1.
  - First valid ifid at the first posedge after rst_n deasserts.
- States: FETCH, HALTED. im_rd_en=1 in FETCH, 0 in HALTED.
- FETCH, priority redirect > stall > normal:
  - redirect=1: pc<=redirect_pc; ifid_valid<=0; ifid_instr<=NOP_INSTR. Overrides stall; the instruction fetched this cycle is squashed and not counted.
  - stall=1 (no redirect): pc, IF/ID and fetch_cnt hold. im_rd_en stays 1 and the IM re-reads the same address.
  - normal: ifid_instr<=im_instr; ifid_pc_plus1<=pc+1; ifid_valid<=1; fetch_cnt+=1 (saturate at 16'hFFFF); pc<=pc+1.
  - If im_instr[15:12]==HLT_OP: the HLT is still delivered to IF/ID, state<=HALTED, halted<=1, and pc holds (does not increment).
- HALTED:
  - pc frozen; ifid_valid<=0 from the next edge; stall ignored.
  - redirect=1 (an older branch resolving after the HLT was fetched): pc<=redirect_pc, state<=FETCH, halted<=0, IF/ID bubble. This exit is required.
- Arithmetic:
  - pc+1 wraps 16'hFFFF -> 16'h0000.
  - ifid_pc_plus1 wraps the same way.
- Simultaneous redirect and stall: redirect wins.
- Simultaneous redirect and an HLT fetch: the HLT is squashed and no halt occurs.

Decomposition:
- Shared package cpu_pkg holds ADDR_W, INSTR_W, HLT_OP, NOP_INSTR, RESET_PC and the fetch state enum {FETCH, HALTED}. The same constants are reused by decode and the hazard unit.
- One natural sub-module, ifid_reg: IF/ID register with load, bubble and async reset. Instantiated here and reused for later pipeline registers.
- PC logic and the FSM stay in instr_fetch.

Test Plan:
- Reset release, IM holding 0x1000..0x1003 at addresses 0..3, no stall -> ifid_instr=0x1000,0x1001,0x1002,0x1003 on consecutive edges; ifid_pc_plus1=1,2,3,4; fetch_cnt=4.
- stall high 3 cycles at pc=5 -> im_addr stays 5 and IF/ID holds; fetch_cnt unchanged; resumes with instr@5 on release.
- redirect=1 with redirect_pc=0x0040 and stall=1 in the same cycle -> ifid_valid=0 next edge, im_addr=0x0040; following edge delivers instr@0x40 with pc_plus1=0x0041.
- HLT 0xF000 at address 7 -> ifid_instr=0xF000 valid, halted=1, im_rd_en=0, ifid_valid=0 thereafter. Then redirect to 0x0010 -> halted=0, fetch resumes at 0x0010.
- pc=16'hFFFF, normal fetch -> ifid_pc_plus1=0x0000, im_addr=0x0000; fetch_cnt preloaded to 0xFFFF stays 0xFFFF.
- rst_n pulsed low mid-clk-low with ifid_valid=1 -> outputs at reset values immediately; fetch restarts at RESET_PC.
